// File: rtl/demux_pkg.sv
// Shared defaults and the destination-select encoding for the stream demultiplexer.
package demux_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

endpackage

// File: rtl/demux_slot.sv
// Single-entry valid/ready output buffer with a handshake counter; load and drain may coincide.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              clr_cnt,
    output logic              can_load,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        drain   = valid_q & out_ready;
        valid_d = load | (valid_q & ~out_ready);
        data_d  = load ? load_data : data_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (drain) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // A full slot can still take new data when its sink drains in the same cycle.
    assign can_load  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/stream_demux.sv
// Routes one input stream to port A or B; each port owns a one-entry slot and a handshake counter.
module stream_demux
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_a_data,
    output logic              out_a_valid,
    input  logic              out_a_ready,
    output logic [DATA_W-1:0] out_b_data,
    output logic              out_b_valid,
    input  logic              out_b_ready,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    port_sel_e sel;
    logic      a_can_load, b_can_load;
    logic      load_a, load_b;

    assign sel      = port_sel_e'(in_sel);
    assign in_ready = (sel == PORT_A) ? a_can_load : b_can_load;
    assign load_a   = in_valid & in_ready & (sel == PORT_A);
    assign load_b   = in_valid & in_ready & (sel == PORT_B);

    demux_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .load      (load_a),
        .load_data (in_data),
        .clr_cnt   (clr_cnt),
        .can_load  (a_can_load),
        .out_data  (out_a_data),
        .out_valid (out_a_valid),
        .out_ready (out_a_ready),
        .cnt       (cnt_a)
    );

    demux_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .load      (load_b),
        .load_data (in_data),
        .clr_cnt   (clr_cnt),
        .can_load  (b_can_load),
        .out_data  (out_b_data),
        .out_valid (out_b_valid),
        .out_ready (out_b_ready),
        .cnt       (cnt_b)
    );

endmodule

// File: tb/tb_stream_demux.sv
// Directed and random checks of stream_demux against a per-port queue model.
module tb_stream_demux;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_a_data, out_b_data;
    logic              out_a_valid, out_b_valid;
    logic              out_a_ready, out_b_ready;
    logic              clr_cnt;
    logic [CNT_W-1:0]  cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: each port is a queue of at most one pending payload.
    logic [DATA_W-1:0] mq [2][$];
    logic [DATA_W-1:0] m_last [2];
    int                m_cnt [2];

    stream_demux #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_a_data  (out_a_data),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b_data  (out_b_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .clr_cnt     (clr_cnt),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                mq[p].delete();
                m_last[p] = '0;
                m_cnt[p]  = 0;
            end
        end else begin
            bit rdy [2];
            bit accept;
            int s;
            rdy[0] = out_a_ready;
            rdy[1] = out_b_ready;
            s      = int'(in_sel);
            accept = in_valid && (mq[s].size() == 0 || rdy[s]);
            for (int p = 0; p < 2; p++) begin
                if (mq[p].size() != 0 && rdy[p]) begin
                    void'(mq[p].pop_front());
                    m_cnt[p] = (m_cnt[p] + 1) % (1 << CNT_W);
                end
                if (clr_cnt) m_cnt[p] = 0;
            end
            if (accept) begin
                mq[s].push_back(in_data);
                m_last[s] = in_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            bit rdy_sel;
            int s;
            s       = int'(in_sel);
            rdy_sel = (s == 0) ? out_a_ready : out_b_ready;
            check("m_in_ready", in_ready, (mq[s].size() == 0) || rdy_sel);
            check("m_a_valid", out_a_valid, mq[0].size() != 0);
            check("m_b_valid", out_b_valid, mq[1].size() != 0);
            check("m_a_data", out_a_data, (mq[0].size() != 0) ? mq[0][0] : m_last[0]);
            check("m_b_data", out_b_data, (mq[1].size() != 0) ? mq[1][0] : m_last[1]);
            check("m_cnt_a", cnt_a, m_cnt[0]);
            check("m_cnt_b", cnt_b, m_cnt[1]);
        end
    end

    initial begin
        rst         = 1'b1;
        in_data     = '0;
        in_sel      = 1'b0;
        in_valid    = 1'b0;
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        clr_cnt     = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_a_valid", out_a_valid, 0);
        check("rst_b_valid", out_b_valid, 0);
        check("rst_a_data", out_a_data, 0);
        check("rst_cnt_b", cnt_b, 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Basic routing to A.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1234;
        tick();
        in_valid = 1'b0;
        check("route_a_valid", out_a_valid, 1);
        check("route_a_data", out_a_data, 16'h1234);
        check("route_b_valid", out_b_valid, 0);
        tick();
        check("route_cnt_a", cnt_a, 1);

        // Back-pressure on A, then replacement with no bubble.
        out_a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hAAAA;
        tick();
        in_data = 16'hBBBB;
        #1;
        check("bp_in_ready", in_ready, 0);
        tick();
        check("bp_a_stable", out_a_data, 16'hAAAA);
        check("bp_cnt_a", cnt_a, 1);
        out_a_ready = 1'b1;
        #1;
        check("bp_in_ready_up", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_a_data_new", out_a_data, 16'hBBBB);
        check("bp_a_valid", out_a_valid, 1);
        check("bp_cnt_a2", cnt_a, 2);

        // Port independence: A full and blocked while B accepts.
        out_a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h5555;
        #1;
        check("ind_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("ind_b_data", out_b_data, 16'h5555);
        check("ind_b_valid", out_b_valid, 1);
        check("ind_a_held", out_a_data, 16'hBBBB);
        tick();
        check("ind_cnt_b", cnt_b, 1);
        out_a_ready = 1'b1;
        tick();
        check("ind_cnt_a", cnt_a, 3);

        // Clear, then 256 B handshakes wrap the counter to 0.
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_cnt_a", cnt_a, 0);
        check("clr_cnt_b", cnt_b, 0);
        in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = DATA_W'(i * 3 + 7);
            tick();
        end
        in_valid = 1'b0;
        check("wrap_cnt_b_255", cnt_b, 255);
        tick();
        check("wrap_cnt_b", cnt_b, 0);

        // clr_cnt wins over a same-cycle A handshake.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0101;
        tick();
        in_data = 16'h0777;
        tick();
        in_valid = 1'b0;
        check("clrpri_pre", cnt_a, 1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clrpri_cnt_a", cnt_a, 0);

        // Async reset with both slots full.
        out_a_ready = 1'b0; out_b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h0A0A;
        tick();
        in_sel = 1'b1; in_data = 16'h0B0B;
        tick();
        in_valid = 1'b0;
        check("pre_rst_a_valid", out_a_valid, 1);
        check("pre_rst_b_valid", out_b_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_a_valid", out_a_valid, 0);
        check("arst_b_valid", out_b_valid, 0);
        check("arst_cnt_b", cnt_b, 0);
        check("arst_b_data", out_b_data, 0);
        check("arst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        out_a_ready = 1'b1; out_b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1111;
        tick();
        in_valid = 1'b0;
        check("post_rst_a_valid", out_a_valid, 1);
        check("post_rst_a_data", out_a_data, 16'h1111);
        check("post_rst_b_valid", out_b_valid, 0);

        // Random stress against the model.
        for (int i = 0; i < 10000; i++) begin
            in_valid    = 1'($urandom_range(0, 1));
            in_sel      = 1'($urandom_range(0, 1));
            in_data     = 16'($urandom);
            out_a_ready = ($urandom_range(0, 3) != 0);
            out_b_ready = ($urandom_range(0, 2) != 0);
            clr_cnt     = ($urandom_range(0, 99) == 0);
            tick();
        end
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
